// File: rtl/tdm_demux4.sv
// tdm_demux4 -- four-slot time-division demultiplexer.
// Hunts for a sync-marked sample, then collects four valid samples per
// frame into channel outputs a..d. A sync seen in the middle of a frame
// restarts the frame and flags sync_err.
// Optional build macro: TDM_DEMUX4_STRICT_SYNC_EN -- when defined, a
// slot-0 sample arriving without sync while locked is a framing error,
// and the block drops back to HUNT.
module tdm_demux4 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             valid,
   input  logic             sync,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] d,
   output logic             s0,
   output logic             s1,
   output logic             frame_valid,
   output logic             sync_err,
   output logic [7:0]       frame_count
);

   typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

   state_t           state;
   logic [1:0]       slot;
   logic [WIDTH-1:0] stage0;
   logic [WIDTH-1:0] stage1;
   logic [WIDTH-1:0] stage2;

   // Slot index is held in a register; s0 is its MSB, s1 its LSB.
   assign s0 = slot[1];
   assign s1 = slot[0];

   // Framing state machine, staging capture and registered channel outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= HUNT;
         slot        <= 2'd0;
         stage0      <= '0;
         stage1      <= '0;
         stage2      <= '0;
         a           <= '0;
         b           <= '0;
         c           <= '0;
         d           <= '0;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
         frame_count <= 8'd0;
      end else begin
         // Status flags are single-cycle pulses.
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
         if (valid) begin
            case (state)
               HUNT: begin
                  if (sync) begin
                     stage0 <= din;
                     slot   <= 2'd1;
                     state  <= LOCKED;
                  end else begin
                     slot <= 2'd0;
                  end
               end
               LOCKED: begin
                  if (sync && (slot != 2'd0)) begin
                     // Mid-frame sync: abandon the partial frame, restart at slot 0.
                     sync_err <= 1'b1;
                     stage0   <= din;
                     slot     <= 2'd1;
                  end
`ifdef TDM_DEMUX4_STRICT_SYNC_EN
                  else if (!sync && (slot == 2'd0)) begin
                     // Frame start without sync marker: lose lock.
                     sync_err <= 1'b1;
                     slot     <= 2'd0;
                     state    <= HUNT;
                  end
`endif
                  else begin
                     case (slot)
                        2'd0: stage0 <= din;
                        2'd1: stage1 <= din;
                        2'd2: stage2 <= din;
                        2'd3: begin
                           // Last slot goes straight to d so the frame lands in one edge.
                           a           <= stage0;
                           b           <= stage1;
                           c           <= stage2;
                           d           <= din;
                           frame_count <= frame_count + 8'd1;
                           frame_valid <= 1'b1;
                        end
                        default: slot <= 2'd0;
                     endcase
                     slot <= slot + 2'd1;
                  end
               end
               default: begin
                  state <= HUNT;
                  slot  <= 2'd0;
               end
            endcase
         end else begin
            state <= state;
         end
      end
   end

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed scenarios plus random
// traffic, all checked each cycle against a frame-level model.
module tb_tdm_demux4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] din = 8'h00;
   logic       valid = 1'b0;
   logic       sync = 1'b0;
   logic [7:0] a, b, c, d;
   logic       s0, s1, frame_valid, sync_err;
   logic [7:0] frame_count;

   int errors = 0;
   int checks = 0;
   int fv_pulses = 0;

   // Behavioural model: lock flag plus the list of samples of the current frame.
   bit         m_locked;
   logic [7:0] m_part[$];
   logic [7:0] m_a, m_b, m_c, m_d, m_fc;
   bit         m_fv, m_se;

   tdm_demux4 #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .din(din), .valid(valid), .sync(sync),
      .a(a), .b(b), .c(c), .d(d), .s0(s0), .s1(s1),
      .frame_valid(frame_valid), .sync_err(sync_err), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model(input bit r, input bit v, input bit s, input logic [7:0] dv);
      m_fv = 1'b0;
      m_se = 1'b0;
      if (r) begin
         m_locked = 1'b0;
         m_part.delete();
         m_a = 8'h00; m_b = 8'h00; m_c = 8'h00; m_d = 8'h00; m_fc = 8'h00;
      end else if (v) begin
         if (!m_locked) begin
            if (s) begin
               m_part.delete();
               m_part.push_back(dv);
               m_locked = 1'b1;
            end
         end else if (s && m_part.size() != 0) begin
            m_se = 1'b1;
            m_part.delete();
            m_part.push_back(dv);
         end
`ifdef TDM_DEMUX4_STRICT_SYNC_EN
         else if (!s && m_part.size() == 0) begin
            m_se = 1'b1;
            m_locked = 1'b0;
         end
`endif
         else begin
            m_part.push_back(dv);
            if (m_part.size() == 4) begin
               m_a = m_part[0]; m_b = m_part[1]; m_c = m_part[2]; m_d = m_part[3];
               m_fc = m_fc + 8'd1;
               m_fv = 1'b1;
               m_part.delete();
            end
         end
      end
   endtask

   // Compare every DUT output against the model.
   task automatic compare();
      logic [1:0] exp_slot;
      exp_slot = m_locked ? 2'(m_part.size()) : 2'd0;
      chk("a", a, m_a);
      chk("b", b, m_b);
      chk("c", c, m_c);
      chk("d", d, m_d);
      chk("slot", {s0, s1}, exp_slot);
      chk("frame_valid", frame_valid, m_fv);
      chk("sync_err", sync_err, m_se);
      chk("frame_count", frame_count, m_fc);
      if (frame_valid === 1'b1) fv_pulses++;
   endtask

   task automatic step(input bit r, input bit v, input bit s, input logic [7:0] dv);
      reset = r; valid = v; sync = s; din = dv;
      model(r, v, s, dv);
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
   endtask

   task automatic clean_frame(input int gap);
      step(1'b0, 1'b1, 1'b1, 8'h11); idle(gap);
      step(1'b0, 1'b1, 1'b0, 8'h22); idle(gap);
      step(1'b0, 1'b1, 1'b0, 8'h33); idle(gap);
      step(1'b0, 1'b1, 1'b0, 8'h44);
   endtask

   task automatic check_clean(input string tag, input logic [7:0] fc);
      chk({tag, "_a"}, a, 8'h11);
      chk({tag, "_b"}, b, 8'h22);
      chk({tag, "_c"}, c, 8'h33);
      chk({tag, "_d"}, d, 8'h44);
      chk({tag, "_fv"}, frame_valid, 1'b1);
      chk({tag, "_fc"}, frame_count, fc);
   endtask

   initial begin
      // Reset state.
      step(1'b1, 1'b1, 1'b1, 8'h99);
      chk("rst_a", a, 8'h00);
      chk("rst_slot", {s0, s1}, 2'd0);
      chk("rst_fc", frame_count, 8'h00);

      // Clean frame.
      clean_frame(0);
      check_clean("clean", 8'd1);
      idle(1);
      chk("clean_fv_drop", frame_valid, 1'b0);
      chk("clean_hold_a", a, 8'h11);

      // Hunt discard.
      step(1'b1, 1'b0, 1'b0, 8'h00);
      fv_pulses = 0;
      step(1'b0, 1'b1, 1'b0, 8'hAA);
      step(1'b0, 1'b1, 1'b0, 8'hBB);
      chk("hunt_slot", {s0, s1}, 2'd0);
      clean_frame(0);
      check_clean("hunt", 8'd1);
      idle(3);
      chk("hunt_pulses", fv_pulses, 1);

      // Gaps of three idle cycles between samples.
      step(1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b1, 8'h11);
      idle(3);
      chk("gap_slot_hold", {s0, s1}, 2'd1);
      step(1'b0, 1'b1, 1'b0, 8'h22); idle(3);
      step(1'b0, 1'b1, 1'b0, 8'h33); idle(3);
      step(1'b0, 1'b1, 1'b0, 8'h44);
      check_clean("gap", 8'd1);

      // Resync mid-frame.
      step(1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b1, 8'h01);
      step(1'b0, 1'b1, 1'b0, 8'h02);
      step(1'b0, 1'b1, 1'b1, 8'h10);
      chk("resync_err", sync_err, 1'b1);
      chk("resync_slot", {s0, s1}, 2'd1);
      step(1'b0, 1'b1, 1'b0, 8'h20);
      chk("resync_err_drop", sync_err, 1'b0);
      step(1'b0, 1'b1, 1'b0, 8'h30);
      step(1'b0, 1'b1, 1'b0, 8'h40);
      chk("resync_a", a, 8'h10);
      chk("resync_d", d, 8'h40);
      chk("resync_fc", frame_count, 8'd1);

      // Reset mid-frame.
      clean_frame(0);
      step(1'b0, 1'b1, 1'b1, 8'h11);
      step(1'b0, 1'b1, 1'b0, 8'h22);
      step(1'b1, 1'b1, 1'b0, 8'h33);
      chk("midrst_a", a, 8'h00);
      chk("midrst_fv", frame_valid, 1'b0);
      chk("midrst_fc", frame_count, 8'h00);
      clean_frame(0);
      check_clean("midrst", 8'd1);

      // Second frame starting without sync.
      step(1'b0, 1'b1, 1'b0, 8'h55);
`ifdef TDM_DEMUX4_STRICT_SYNC_EN
      chk("strict_err", sync_err, 1'b1);
      chk("strict_slot", {s0, s1}, 2'd0);
      step(1'b0, 1'b1, 1'b0, 8'h66);
      chk("strict_hunt_slot", {s0, s1}, 2'd0);
      chk("strict_fc", frame_count, 8'd1);
`else
      chk("lax_err", sync_err, 1'b0);
      chk("lax_slot", {s0, s1}, 2'd1);
      step(1'b0, 1'b1, 1'b0, 8'h66);
      step(1'b0, 1'b1, 1'b0, 8'h77);
      step(1'b0, 1'b1, 1'b0, 8'h88);
      chk("lax_a", a, 8'h55);
      chk("lax_fc", frame_count, 8'd2);
`endif

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         step(1'($urandom_range(0, 199) == 0),
              1'($urandom_range(0, 9) < 7),
              1'($urandom_range(0, 5) == 0),
              8'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
